// File: rtl/lcd_page_writer.sv
// +--------------------------------------------------------------------------+
// | lcd_page_writer: pulls column bytes from the RAM controller and refreshes |
// | a KS0108-style 128x64 LCD page by page. Option macro: LCD_BOTH_HALVES_EN  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module lcd_page_writer #(
   parameter int E_HIGH   = 4,
   parameter int E_LOW    = 4,
   parameter int RST_CYC  = 16,
   parameter int WAIT_MAX = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       data_valid,
   input  logic [7:0] data,
   output logic       en,
   output logic       LCD_rst,
   output logic [1:0] LCD_cs,
   output logic       LCD_rw,
   output logic       LCD_di,
   output logic [7:0] LCD_data,
   output logic       LCD_en,
   output logic       frame_done
);

   localparam logic [2:0] S_RST_LCD  = 3'd0;
   localparam logic [2:0] S_INIT     = 3'd1;
   localparam logic [2:0] S_SET_PAGE = 3'd2;
   localparam logic [2:0] S_SET_COL  = 3'd3;
   localparam logic [2:0] S_REQ      = 3'd4;
   localparam logic [2:0] S_WAIT     = 3'd5;
   localparam logic [2:0] S_WR_DATA  = 3'd6;

   localparam logic [15:0] c_RST_LAST  = 16'(RST_CYC - 1);
   localparam logic [15:0] c_WR_LAST   = 16'(E_HIGH + E_LOW);
   localparam logic [15:0] c_EN_LAST   = 16'(E_HIGH);
   localparam logic [15:0] c_WAIT_LAST = 16'(WAIT_MAX - 1);

`ifdef LCD_BOTH_HALVES_EN
   localparam logic [1:0] c_CS_DATA = 2'b11;
`else
   localparam logic [1:0] c_CS_DATA = 2'b01;
`endif

   logic [2:0]  r_state;
   logic [15:0] r_cnt;
   logic        r_init_idx;
   logic [5:0]  r_col;
   logic [2:0]  r_page;
   logic [7:0]  r_hold;
   logic        r_lcd_rst;
   logic        r_frame_done;

   logic w_writing;
   logic w_wr_done;

   assign w_writing = (r_state == S_INIT) || (r_state == S_SET_PAGE) ||
                      (r_state == S_SET_COL) || (r_state == S_WR_DATA);
   assign w_wr_done = w_writing && (r_cnt == c_WR_LAST);

   // r_cnt is shared: reset hold time, bus-write phase and WAIT timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_RST_LCD;
         r_cnt        <= '0;
         r_init_idx   <= 1'b0;
         r_col        <= '0;
         r_page       <= '0;
         r_hold       <= '0;
         r_lcd_rst    <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (w_writing) begin
            r_cnt <= w_wr_done ? 16'd0 : r_cnt + 16'd1;
         end
         case (r_state)
            S_RST_LCD: begin
               if (r_cnt == c_RST_LAST) begin
                  r_lcd_rst <= 1'b1;
                  r_state   <= S_INIT;
                  r_cnt     <= '0;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_INIT: begin
               if (w_wr_done) begin
                  r_init_idx <= ~r_init_idx;
                  if (r_init_idx) r_state <= S_SET_PAGE;
               end
            end
            S_SET_PAGE: if (w_wr_done) r_state <= S_SET_COL;
            S_SET_COL:  if (w_wr_done) r_state <= S_REQ;
            S_REQ: begin
               r_state <= S_WAIT;
               r_cnt   <= '0;
            end
            S_WAIT: begin
               if (data_valid) begin
                  r_hold  <= data;
                  r_state <= S_WR_DATA;
                  r_cnt   <= '0;
               end else if (r_cnt == c_WAIT_LAST) begin
                  r_state <= S_REQ;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_WR_DATA: begin
               if (w_wr_done) begin
                  r_col <= r_col + 6'd1;
                  if (r_col == 6'd63) begin
                     r_page  <= r_page + 3'd1;
                     r_state <= S_SET_PAGE;
                     if (r_page == 3'd7) r_frame_done <= 1'b1;
                  end else begin
                     r_state <= S_REQ;
                  end
               end
            end
            default: begin
               r_state <= S_RST_LCD;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   always_comb begin
      LCD_cs   = 2'b00;
      LCD_di   = 1'b0;
      LCD_data = 8'h00;
      case (r_state)
         S_INIT: begin
            LCD_cs   = 2'b11;
            LCD_data = r_init_idx ? 8'hC0 : 8'h3F;
         end
         S_SET_PAGE: begin
            LCD_cs   = c_CS_DATA;
            LCD_data = {5'b10111, r_page};
         end
         S_SET_COL: begin
            LCD_cs   = c_CS_DATA;
            LCD_data = 8'h40;
         end
         S_WR_DATA: begin
            LCD_cs   = c_CS_DATA;
            LCD_di   = 1'b1;
            LCD_data = r_hold;
         end
         default: ;
      endcase
   end

   // Strobe is decoded from the async-reset counter so reset drops it at once.
   assign LCD_en     = w_writing && (r_cnt >= 16'd1) && (r_cnt <= c_EN_LAST);
   assign en         = (r_state == S_REQ);
   assign LCD_rst    = r_lcd_rst;
   assign LCD_rw     = 1'b0;
   assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_lcd_page_writer.sv
// +--------------------------------------------------------------------------+
// | tb_lcd_page_writer: randomized bench with a frame-level reference model   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_lcd_page_writer;

   localparam int E_HIGH   = 4;
   localparam int E_LOW    = 4;
   localparam int RST_CYC  = 16;
   localparam int WAIT_MAX = 3;
   localparam int WR_LEN   = 1 + E_HIGH + E_LOW;
   localparam int FRAME_END = 2 + 66 * 8;
`ifdef LCD_BOTH_HALVES_EN
   localparam logic [1:0] CSD = 2'b11;
`else
   localparam logic [1:0] CSD = 2'b01;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       data_valid = 1'b0;
   logic [7:0] data = 8'h00;
   logic       en, LCD_rst, LCD_rw, LCD_di, LCD_en, frame_done;
   logic [1:0] LCD_cs;
   logic [7:0] LCD_data;

   lcd_page_writer #(.E_HIGH(E_HIGH), .E_LOW(E_LOW), .RST_CYC(RST_CYC), .WAIT_MAX(WAIT_MAX)) dut (
      .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .data(data), .en(en),
      .LCD_rst(LCD_rst), .LCD_cs(LCD_cs), .LCD_rw(LCD_rw), .LCD_di(LCD_di),
      .LCD_data(LCD_data), .LCD_en(LCD_en), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] cs;
      logic       di;
      logic [7:0] d;
      int         hi;
      bit         stable;
      int         rise;
   } wr_t;

   int checks = 0, failures = 0, cyc = 0;
   wr_t        wq[$];
   logic [7:0] exp_q[$];
   int         plan_q[$];
   int         gap_q[$];
   int         fd_cyc[$];
   int         pend = 0, pend_d = 0, bmode = 0, last_en = -100;
   bit         rnd_mode = 0, stray_on = 0, stray_pend = 0, last_ign = 0;
   logic [7:0] pend_byte = 8'h00, bctr = 8'h00, bfixed = 8'h00;
   int         en_consec = 0, en_during_write = 0, hold_bad = 0, hold_left = 0;
   bit         p_en = 0;
   logic [1:0] p_cs = 2'b00;
   logic       p_di = 1'b0;
   logic [7:0] p_d = 8'h00;
   wr_t        cur;

   // Expected bus write number 'pos' since the LCD came out of reset.
   function automatic void exp_write(input int pos, output logic [1:0] cs, output logic di,
                                     output logic [7:0] d, output bit is_data);
      int k, j, pg;
      is_data = 0; di = 1'b0; cs = CSD; d = 8'h00;
      if (pos == 0) begin cs = 2'b11; d = 8'h3F; end
      else if (pos == 1) begin cs = 2'b11; d = 8'hC0; end
      else begin
         k = pos - 2; j = k % 66; pg = (k / 66) % 8;
         if (j == 0) d = 8'hB8 + 8'(pg);
         else if (j == 1) d = 8'h40;
         else begin is_data = 1; di = 1'b1; end
      end
   endfunction

   // One clock: responder drive, then bus/en/frame_done observation.
   task automatic tick();
      int d, r;
      @(posedge clk); #1; cyc++;
      data_valid = 1'b0;
      if (stray_pend) begin data_valid = 1'b1; data = ~pend_byte; stray_pend = 0; end
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            data_valid = 1'b1; data = pend_byte;
            if (pend_d <= WAIT_MAX) begin
               exp_q.push_back(pend_byte);
               if (stray_on) stray_pend = 1;
            end
         end
      end
      if (en) begin
         if (last_en == cyc - 1) en_consec++;
         if (last_ign) gap_q.push_back(cyc - last_en);
         if (LCD_cs != 2'b00 || LCD_en) en_during_write++;
         if (plan_q.size() != 0) d = plan_q.pop_front();
         else if (rnd_mode) begin
            r = int'($urandom_range(9, 0));
            d = (r == 0) ? 0 : (r == 1) ? WAIT_MAX + 1 : (r % 3) + 1;
         end else d = 1;
         last_ign = (d == 0) || (d > WAIT_MAX);
         last_en  = cyc;
         if (d != 0) begin
            pend = d; pend_d = d;
            case (bmode)
               1: begin pend_byte = bctr; bctr++; end
               2: pend_byte = bfixed;
               default: pend_byte = 8'($urandom);
            endcase
         end
      end
      if (hold_left > 0) begin
         if (LCD_en || LCD_cs != cur.cs || LCD_di != cur.di || LCD_data != cur.d) hold_bad++;
         hold_left--;
      end
      if (LCD_en && !p_en) begin
         cur.cs = LCD_cs; cur.di = LCD_di; cur.d = LCD_data; cur.hi = 1; cur.rise = cyc;
         cur.stable = (p_cs == LCD_cs) && (p_di == LCD_di) && (p_d == LCD_data) && (LCD_cs != 2'b00);
      end else if (LCD_en) begin
         cur.hi++;
         if (LCD_cs != cur.cs || LCD_di != cur.di || LCD_data != cur.d) cur.stable = 0;
      end else if (p_en) begin
         if (LCD_cs != cur.cs || LCD_di != cur.di || LCD_data != cur.d) cur.stable = 0;
         wq.push_back(cur);
         hold_left = E_LOW - 1;
      end
      if (frame_done) fd_cyc.push_back(cyc);
      p_en = LCD_en; p_cs = LCD_cs; p_di = LCD_di; p_d = LCD_data;
   endtask

   task automatic get_write(output wr_t w, output bit ok);
      int n = 0;
      while (wq.size() == 0 && n < 2000) begin tick(); n++; end
      ok = (wq.size() != 0);
      if (ok) w = wq.pop_front();
   endtask

   task automatic count_lcd_rst(output int n);
      n = 0;
      do begin tick(); n++; end while (LCD_rst == 1'b0 && n < 100);
   endtask

   task automatic test_reset();
      int n;
      rst_n = 1'b0;
      repeat (5) tick();
      checks++;
      if ({en, LCD_rst, LCD_cs, LCD_rw, LCD_di, LCD_data, LCD_en, frame_done} !== 15'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h expected=0",
                  {en, LCD_rst, LCD_cs, LCD_rw, LCD_di, LCD_data, LCD_en, frame_done});
      end
      rst_n = 1'b1; bmode = 1; bctr = 8'h00;
      count_lcd_rst(n);
      checks++;
      if (n !== RST_CYC) begin
         failures++; $display("FAIL reset_lcd_rst_len got=%0d expected=%0d", n, RST_CYC);
      end
   endtask

   task automatic test_init();
      wr_t w; bit ok, isd; logic [1:0] ecs; logic edi; logic [7:0] ed; int prev_rise = 0;
      for (int p = 0; p < 4; p++) begin
         get_write(w, ok); exp_write(p, ecs, edi, ed, isd);
         checks++;
         if (!ok) begin failures++; $display("FAIL init_timeout pos=%0d got=none expected=write", p); end
         else begin
            checks++;
            if ({w.cs, w.di, w.d} !== {ecs, edi, ed}) begin
               failures++; $display("FAIL init_write pos=%0d got=%h expected=%h", p, {w.cs, w.di, w.d}, {ecs, edi, ed});
            end
            checks++;
            if (w.hi !== E_HIGH || !w.stable) begin
               failures++; $display("FAIL init_strobe pos=%0d got_hi=%0d stable=%0d expected_hi=%0d", p, w.hi, w.stable, E_HIGH);
            end
            if (p > 0) begin
               checks++;
               if (w.rise - prev_rise !== WR_LEN) begin
                  failures++; $display("FAIL init_spacing pos=%0d got=%0d expected=%0d", p, w.rise - prev_rise, WR_LEN);
               end
            end
            prev_rise = w.rise;
         end
      end
   endtask

   task automatic test_page0();
      wr_t w; bit ok; logic [7:0] eb;
      for (int c = 0; c < 64; c++) begin
         get_write(w, ok);
         eb = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
         checks++;
         if (!ok || {w.cs, w.di, w.d} !== {CSD, 1'b1, 8'(c)} || eb !== 8'(c)) begin
            failures++; $display("FAIL page0_data col=%0d got=%h expected=%h", c, {w.cs, w.di, w.d}, {CSD, 1'b1, 8'(c)});
         end
      end
      get_write(w, ok);
      checks++;
      if (!ok || {w.cs, w.di, w.d} !== {CSD, 1'b0, 8'hB9}) begin
         failures++; $display("FAIL page0_next_instr got=%h expected=%h", {w.cs, w.di, w.d}, {CSD, 1'b0, 8'hB9});
      end
      checks++;
      if (fd_cyc.size() !== 0) begin
         failures++; $display("FAIL page0_no_frame_done got=%0d expected=0", fd_cyc.size());
      end
   endtask

   task automatic test_retry();
      wr_t w; bit ok; logic [7:0] eb;
      gap_q.delete();
      plan_q.push_back(0); plan_q.push_back(0); plan_q.push_back(1);
      bmode = 2; bfixed = 8'hA5;
      get_write(w, ok);
      checks++;
      if (!ok || {w.cs, w.di, w.d} !== {CSD, 1'b0, 8'h40}) begin
         failures++; $display("FAIL retry_setcol got=%h expected=%h", {w.cs, w.di, w.d}, {CSD, 1'b0, 8'h40});
      end
      get_write(w, ok);
      bmode = 0;
      eb = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (!ok || {w.cs, w.di, w.d} !== {CSD, 1'b1, 8'hA5} || eb !== 8'hA5) begin
         failures++; $display("FAIL retry_data got=%h expected=%h", {w.cs, w.di, w.d}, {CSD, 1'b1, 8'hA5});
      end
      checks++;
      if (exp_q.size() !== 0) begin
         failures++; $display("FAIL retry_dup got=%0d expected=0 extra bytes", exp_q.size());
      end
      checks++;
      if (gap_q.size() !== 2) begin
         failures++; $display("FAIL retry_gap_count got=%0d expected=2", gap_q.size());
      end
      foreach (gap_q[i]) begin
         checks++;
         if (gap_q[i] !== WAIT_MAX + 1) begin
            failures++; $display("FAIL retry_gap got=%0d expected=%0d", gap_q[i], WAIT_MAX + 1);
         end
      end
   endtask

   task automatic test_frame();
      wr_t w; bit ok, isd; logic [1:0] ecs; logic edi; logic [7:0] ed; int last_rise = 0, bad = 0;
      gap_q.delete(); rnd_mode = 1; stray_on = 1;
      for (int p = 71; p < FRAME_END; p++) begin
         get_write(w, ok); exp_write(p, ecs, edi, ed, isd);
         if (isd) ed = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
         checks++;
         if (!ok || {w.cs, w.di, w.d} !== {ecs, edi, ed} || w.hi !== E_HIGH || !w.stable) begin
            failures++; bad++;
            if (bad < 10) $display("FAIL frame_write pos=%0d got=%h hi=%0d expected=%h", p, {w.cs, w.di, w.d}, w.hi, {ecs, edi, ed});
         end
         last_rise = w.rise;
      end
      get_write(w, ok);
      checks++;
      if (!ok || {w.cs, w.di, w.d} !== {CSD, 1'b0, 8'hB8}) begin
         failures++; $display("FAIL frame_wrap_instr got=%h expected=%h", {w.cs, w.di, w.d}, {CSD, 1'b0, 8'hB8});
      end
      checks++;
      if (fd_cyc.size() !== 1) begin
         failures++; $display("FAIL frame_done_count got=%0d expected=1", fd_cyc.size());
      end else begin
         checks++;
         if (!(fd_cyc[0] > last_rise && fd_cyc[0] < w.rise)) begin
            failures++; $display("FAIL frame_done_time got=%0d expected_between=%0d..%0d", fd_cyc[0], last_rise, w.rise);
         end
      end
      foreach (gap_q[i]) begin
         checks++;
         if (gap_q[i] !== WAIT_MAX + 1) begin
            failures++; $display("FAIL frame_retry_gap got=%0d expected=%0d", gap_q[i], WAIT_MAX + 1);
         end
      end
      checks++;
      if (en_consec !== 0 || en_during_write !== 0 || hold_bad !== 0) begin
         failures++; $display("FAIL protocol got consec=%0d en_in_write=%0d hold_bad=%0d expected=0", en_consec, en_during_write, hold_bad);
      end
   endtask

   task automatic test_midreset();
      wr_t w; bit ok; int n = 0;
      rnd_mode = 0; stray_on = 0;
      while (!LCD_en && n < 200) begin tick(); n++; end
      checks++;
      if (!LCD_en) begin failures++; $display("FAIL midreset_strobe got=0 expected=1"); end
      rst_n = 1'b0; #1;
      checks++;
      if ({en, LCD_rst, LCD_cs, LCD_di, LCD_data, LCD_en, frame_done} !== 14'd0) begin
         failures++; $display("FAIL midreset_outputs got=%h expected=0", {en, LCD_rst, LCD_cs, LCD_di, LCD_data, LCD_en, frame_done});
      end
      repeat (3) tick();
      wq.delete(); exp_q.delete(); plan_q.delete(); fd_cyc.delete();
      pend = 0; stray_pend = 0; p_en = 0; hold_left = 0; last_ign = 0; last_en = -100;
      rst_n = 1'b1;
      count_lcd_rst(n);
      checks++;
      if (n !== RST_CYC) begin failures++; $display("FAIL midreset_lcd_rst_len got=%0d expected=%0d", n, RST_CYC); end
      get_write(w, ok);
      checks++;
      if (!ok || {w.cs, w.di, w.d} !== {2'b11, 1'b0, 8'h3F} || w.hi !== E_HIGH) begin
         failures++; $display("FAIL midreset_reinit got=%h hi=%0d expected=%h", {w.cs, w.di, w.d}, w.hi, {2'b11, 1'b0, 8'h3F});
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_page0();
      test_retry();
      test_frame();
      test_midreset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
